// File: rtl/rep3_serial_tx.sv
// Triple-redundant serial transmitter: frames each word as start/data/stop
// triplets, every bit repeated as three identical chips, LSB first.
module rep3_serial_tx #(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_CHIP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy
);

    localparam int CYC_W = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_CHIP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nx;
    logic [CYC_W-1:0]   cyc, cyc_nx;
    logic [1:0]         chip, chip_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [DATA_W-1:0]  shift, shift_nx;
    logic               tx_nx, ready_nx, busy_nx;
    logic               phase_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= '0;
            chip      <= '0;
            idx       <= '0;
            shift     <= '0;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cyc       <= cyc_nx;
            chip      <= chip_nx;
            idx       <= idx_nx;
            shift     <= shift_nx;
            tx_out    <= tx_nx;
            ready_out <= ready_nx;
            busy      <= busy_nx;
        end
    end

    // A phase (start, one data bit, stop) ends on the last cycle of its third chip.
    assign phase_end = (cyc == CYC_LAST) && (chip == 2'd2);

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        chip_nx  = chip;
        idx_nx   = idx;
        shift_nx = shift;

        if (state == IDLE) begin
            if (valid_in && ready_out) begin
                state_nx = START;
                shift_nx = data_in;
                cyc_nx   = '0;
                chip_nx  = '0;
                idx_nx   = '0;
            end
        end else begin
            if (cyc == CYC_LAST) begin
                cyc_nx  = '0;
                chip_nx = (chip == 2'd2) ? 2'd0 : chip + 2'd1;
            end else begin
                cyc_nx = cyc + 1'b1;
            end

            if (phase_end) begin
                idx_nx = '0;
                case (state)
                    START: state_nx = DATA;
                    DATA: begin
                        shift_nx = shift >> 1;
                        if (idx == IDX_LAST) state_nx = STOP;
                        else                 idx_nx   = idx + 1'b1;
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end

        // Outputs are computed from the next state so they register in step with it.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
        ready_nx = (state_nx == IDLE);
        busy_nx  = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed bench for rep3_serial_tx: an 8-bit/2-clock instance and a 1-bit/1-clock corner instance.
module tb_rep3_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_a = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, tx_a, busy_a;
    logic [0:0] data_b = '0;
    logic       valid_b = 1'b0;
    logic       ready_b, tx_b, busy_b;

    int n_vec = 0;
    int n_err = 0;

    rep3_serial_tx #(.DATA_W(8), .CLKS_PER_CHIP(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .tx_out(tx_a), .busy(busy_a)
    );

    rep3_serial_tx #(.DATA_W(1), .CLKS_PER_CHIP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .tx_out(tx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge; walks the 60-cycle frame of dut_a and
    // ends just after the edge that returns it to idle.
    task automatic run_frame(input string tag, input logic [9:0] trip, input bit scramble);
        logic [2:0] chips;
        logic [7:0] rec;
        int t;
        chips = '0;
        rec   = '0;
        for (int c = 0; c < 60; c++) begin
            t = c / 6;
            if (scramble) data_a = 8'($urandom);
            chk({tag, "_tx"}, {7'd0, tx_a}, {7'd0, trip[t]});
            chk({tag, "_ready"}, {7'd0, ready_a}, 8'd0);
            chk({tag, "_busy"}, {7'd0, busy_a}, 8'd1);
            if ((c % 2) == 0) chips[(c % 6) / 2] = tx_a;
            if ((c % 6) == 4 && t >= 1 && t <= 8)
                rec[t-1] = (chips[0] & chips[1]) | (chips[0] & chips[2]) | (chips[1] & chips[2]);
            tick();
        end
        chk({tag, "_vote"}, rec, trip[8:1]);
        chk({tag, "_end_ready"}, {7'd0, ready_a}, 8'd1);
        chk({tag, "_end_busy"}, {7'd0, busy_a}, 8'd0);
        chk({tag, "_end_tx"}, {7'd0, tx_a}, 8'd1);
    endtask

    task automatic chk_accept(input string tag);
        chk({tag, "_acc_tx"}, {7'd0, tx_a}, 8'd0);
        chk({tag, "_acc_ready"}, {7'd0, ready_a}, 8'd0);
        chk({tag, "_acc_busy"}, {7'd0, busy_a}, 8'd1);
    endtask

    initial begin
        logic [8:0] exp_b;

        // Reset held with valid asserted: nothing starts.
        valid_a = 1'b1;
        valid_b = 1'b1;
        data_a  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_tx", {7'd0, tx_a}, 8'd1);
            chk("rst_ready", {7'd0, ready_a}, 8'd1);
            chk("rst_busy", {7'd0, busy_a}, 8'd0);
            chk("rst_b_tx", {7'd0, tx_b}, 8'd1);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("idle_ready", {7'd0, ready_a}, 8'd1);
        chk("idle_tx", {7'd0, tx_a}, 8'd1);

        // Corner instance: DATA_W=1, CLKS_PER_CHIP=1, send 1.
        exp_b   = 9'b111111000;
        data_b  = 1'b1;
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        for (int c = 0; c < 9; c++) begin
            chk("b_tx", {7'd0, tx_b}, {7'd0, exp_b[c]});
            chk("b_busy", {7'd0, busy_b}, 8'd1);
            tick();
        end
        chk("b_end_ready", {7'd0, ready_b}, 8'd1);
        chk("b_end_tx", {7'd0, tx_b}, 8'd1);

        // Single word 0xA5.
        data_a  = 8'hA5;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        chk_accept("a5");
        run_frame("a5", 10'b1101001010, 1'b0);
        tick();

        // Back-to-back with valid held: 0x00 then 0xFF, one idle-high cycle between.
        data_a  = 8'h00;
        valid_a = 1'b1;
        tick();
        chk_accept("b2b0");
        data_a = 8'hFF;
        run_frame("b2b0", 10'b1000000000, 1'b0);
        tick();
        chk_accept("b2b1");
        valid_a = 1'b0;
        run_frame("b2b1", 10'b1111111110, 1'b0);
        tick();

        // Data stability: data_in scrambled every cycle after accepting 0x5A.
        data_a  = 8'h5A;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        chk_accept("stab");
        run_frame("stab", 10'b1010110100, 1'b1);
        tick();

        // Reset during DATA bit 3 of 0x96 (bit 3 = 0).
        data_a  = 8'h96;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int c = 0; c < 26; c++) tick();
        chk("mid_tx_before", {7'd0, tx_a}, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_tx_async", {7'd0, tx_a}, 8'd1);
        chk("mid_ready_async", {7'd0, ready_a}, 8'd1);
        chk("mid_busy_async", {7'd0, busy_a}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {7'd0, ready_a}, 8'd1);
        chk("post_rst_tx", {7'd0, tx_a}, 8'd1);

        data_a  = 8'h3C;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        chk_accept("3c");
        run_frame("3c", 10'b1001111000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
